shift_align_ctrl: RTL and testbench



---
 rtl/shift_align_pkg.sv | 14 +
 rtl/shift_align_ctrl_align_counter.sv | 39 +++
 rtl/shift_align_ctrl.sv | 126 ++++++++++++
 tb/tb_shift_align_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_align_pkg.sv
// rtl/shift_align_pkg.sv - shared state encoding and sizing for the shift alignment controller
package shift_align_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/shift_align_ctrl_align_counter.sv
// rtl/shift_align_ctrl_align_counter.sv - shift counter with clear, increment and terminal flag at WIDTH-1
module align_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment so a fresh operand always starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_align_ctrl.sv
// rtl/shift_align_ctrl.sv - load/shift controller that left-aligns an operand's leading one; ALIGN_TIMEOUT_EN adds err
module shift_align_ctrl
  import shift_align_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_load,
  output logic             sr_shift_en,
  output logic             sr_in_sh,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             zero,
  output logic             busy,
`ifdef ALIGN_TIMEOUT_EN
  output logic             err,
`endif
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic             zero_q, zero_d;
  logic             accept;
  logic             msb;
  logic             cnt_term;
  logic             shift_en;

  assign accept = (state_q == IDLE) && start;
  assign msb    = sr_out[WIDTH-1];

  // Shift only while scanning a nonzero operand whose MSB is not yet set;
  // the terminal count stops a runaway scan if the register disagrees with us
  assign shift_en = (state_q == SCAN) && !zero_q && !msb && !cnt_term;

  align_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (shift_en),
    .cnt  (shift_cnt),
    .term (cnt_term)
  );

  // Next-state and operand capture
  always_comb begin
    state_d   = state_q;
    sr_data_d = sr_data_q;
    zero_d    = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_data_d = data_in;
          zero_d    = (data_in == '0);
          state_d   = LOAD;
        end
      end
      LOAD: state_d = SCAN;
      SCAN: begin
        if (!shift_en) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_data_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_data_q <= sr_data_d;
      zero_q    <= zero_d;
    end
  end

`ifdef ALIGN_TIMEOUT_EN
  logic err_q, err_d;
  logic guard;

  assign guard = (state_q == SCAN) && !zero_q && !msb && cnt_term;

  // Sticky error when the scan gives up; a newly accepted operand clears it
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (guard) begin
      err_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign sr_data     = sr_data_q;
  assign zero        = zero_q;
  assign sr_load     = (state_q == LOAD);
  assign sr_shift_en = shift_en;
  assign sr_in_sh    = 1'b0;
  assign busy        = (state_q == LOAD) || (state_q == SCAN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_shift_align_ctrl.sv
// tb/tb_shift_align_ctrl.sv - directed vector bench for shift_align_ctrl with a downstream shift register model
module tb_shift_align_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] sr_out;
  logic [15:0] sr_data;
  logic        sr_load;
  logic        sr_shift_en;
  logic        sr_in_sh;
  logic [3:0]  shift_cnt;
  logic        zero;
  logic        busy;
  logic        done;
`ifdef ALIGN_TIMEOUT_EN
  logic        err;
`endif

  logic [15:0] sr_m;
  logic        force_lo;

  int checks;
  int errors;
  int done_edge;
  int n_load;
  int n_shift;
  int overlap;

  shift_align_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .sr_out      (sr_out),
    .sr_data     (sr_data),
    .sr_load     (sr_load),
    .sr_shift_en (sr_shift_en),
    .sr_in_sh    (sr_in_sh),
    .shift_cnt   (shift_cnt),
    .zero        (zero),
    .busy        (busy),
`ifdef ALIGN_TIMEOUT_EN
    .err         (err),
`endif
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 16-bit shift register
  always @(posedge clk) begin
    if (sr_load) sr_m <= sr_data;
    else if (sr_shift_en) sr_m <= {sr_m[14:0], sr_in_sh};
  end

  assign sr_out = force_lo ? {1'b0, sr_m[14:0]} : sr_m;

  typedef struct {
    logic [15:0] din;
    int          inj;
    int          exp_done;
    logic [3:0]  exp_cnt;
    logic        exp_zero;
    logic [15:0] exp_sr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] din, input int inj);
    @(negedge clk);
    start   = 1'b1;
    data_in = din;
    @(posedge clk);
    #1;
    start     = 1'b0;
    done_edge = -1;
    n_load    = 0;
    n_shift   = 0;
    overlap   = 0;
    for (int e = 0; e < 40 && done_edge < 0; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (e == inj) begin
        start   = 1'b1;
        data_in = 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (sr_load) n_load++;
      if (sr_shift_en) n_shift++;
      if (sr_load && sr_shift_en) overlap++;
      if (done) done_edge = e;
    end
    start = 1'b0;
  endtask

  initial begin
    int no_done;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    data_in  = 16'h0;
    force_lo = 1'b0;
    sr_m     = 16'h0;

    vecs[0] = '{16'h0001, -1, 17, 4'd15, 1'b0, 16'h8000};
    vecs[1] = '{16'h8000, -1,  2, 4'd0,  1'b0, 16'h8000};
    vecs[2] = '{16'h0000, -1,  2, 4'd0,  1'b1, 16'h0000};
    vecs[3] = '{16'h00F3,  4, 10, 4'd8,  1'b0, 16'hF300};
    vecs[4] = '{16'h4000, -1,  3, 4'd1,  1'b0, 16'h8000};
    vecs[5] = '{16'h0100, -1,  9, 4'd7,  1'b0, 16'h8000};
    vecs[6] = '{16'h0020, -1, 12, 4'd10, 1'b0, 16'h8000};

    repeat (2) @(posedge clk);
    #1;
    check("rst_sr_data", 32'(sr_data), 32'h0);
    check("rst_cnt", 32'(shift_cnt), 32'h0);
    check("rst_flags", {27'h0, zero, sr_load, sr_shift_en, busy, done}, 32'h0);
    check("rst_in_sh", 32'(sr_in_sh), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a scan of 16'h0001
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sr_data", 32'(sr_data), 32'h0);
    check("mid_rst_cnt", 32'(shift_cnt), 32'h0);
    check("mid_rst_flags", {27'h0, zero, sr_load, sr_shift_en, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    no_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) no_done++;
    end
    check("post_rst_quiet", 32'(no_done), 32'h0);

    // Table of operands
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].din, vecs[i].inj);
      check($sformatf("v%0d_done_edge", i), 32'(done_edge), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_cnt", i), 32'(shift_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
      check($sformatf("v%0d_shifts", i), 32'(n_shift), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_loads", i), 32'(n_load), 32'h1);
      check($sformatf("v%0d_overlap", i), 32'(overlap), 32'h0);
      check($sformatf("v%0d_sr_out", i), 32'(sr_out), 32'(vecs[i].exp_sr));
      check($sformatf("v%0d_sr_data", i), 32'(sr_data), 32'(vecs[i].din));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_after_done", i), {30'h0, busy, done}, 32'h0);
    end

    // start presented while in DONE is dropped
    run_op(16'h8000, -1);
    check("dstart_done_edge", 32'(done_edge), 32'h2);
    start   = 1'b1;
    data_in = 16'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("dstart_busy", {30'h0, busy, done}, 32'h0);
    check("dstart_sr_data", 32'(sr_data), 32'h8000);

`ifdef ALIGN_TIMEOUT_EN
    // Register MSB stuck at 0: scan must give up at the terminal count
    force_lo = 1'b1;
    run_op(16'h0004, -1);
    check("to_done_edge", 32'(done_edge), 32'd17);
    check("to_cnt", 32'(shift_cnt), 32'd15);
    check("to_shifts", 32'(n_shift), 32'd15);
    check("to_err", 32'(err), 32'h1);
    force_lo = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h8000;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("to_err_clear", 32'(err), 32'h0);
    repeat (4) @(posedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
